ir_shot_sequencer: RTL and testbench

Fire-control sequencer for the tank's IR transmitter. A one-cycle fire request becomes a timed, team-coded IR frame by switching the carrier-frequency code that drives the 56/38 kHz carrier mux on and off. The block enforces ammunition and cooldown limits, and reports shot completion and rejected requests. It sits between the APB3 register block, which supplies fire, team, frequency and ammo values, and the IR carrier PWM mux.

---
 rtl/ir_shot_sequencer_pkg.sv | 31 +++
 rtl/ir_shot_sequencer_if.sv | 24 ++
 rtl/ir_shot_sequencer_unit_timer.sv | 32 +++
 rtl/ir_shot_sequencer.sv | 142 ++++++++++++++
 tb/tb_ir_shot_sequencer.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/ir_shot_sequencer_pkg.sv
// Shared types and constants for the IR shot sequencer: FSM states,
// frame segment lengths in code units, and carrier-frequency codes.
package ir_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR_MARK,
        HDR_SPACE,
        BIT_MARK,
        BIT_SPACE,
        COOLDOWN
    } seq_state_t;

    localparam int unsigned HDR_MARK_UNITS  = 4;
    localparam int unsigned SPACE_UNITS     = 1;
    localparam int unsigned ONE_MARK_UNITS  = 2;
    localparam int unsigned ZERO_MARK_UNITS = 1;

    localparam logic [5:0] FREQ_56  = 6'd56;
    localparam logic [5:0] FREQ_38  = 6'd38;
    localparam logic [5:0] FREQ_OFF = 6'd0;

    function automatic logic is_mark(seq_state_t s);
        return (s == HDR_MARK) || (s == BIT_MARK);
    endfunction

    function automatic logic freq_legal(logic [5:0] f);
        return (f == FREQ_56) || (f == FREQ_38);
    endfunction

endpackage

// File: rtl/ir_shot_sequencer_if.sv
// Fire-control bundle between the register block (master) and the
// IR shot sequencer (slave).
interface ir_shot_sequencer_if;
    logic       fire;
    logic [3:0] team_id;
    logic [5:0] freq_sel;
    logic       ammo_load;
    logic [7:0] ammo_val;
    logic [5:0] ir_freq;
    logic       busy;
    logic       shot_done;
    logic       fire_drop;
    logic [7:0] ammo;

    modport master (
        output fire, team_id, freq_sel, ammo_load, ammo_val,
        input  ir_freq, busy, shot_done, fire_drop, ammo
    );

    modport slave (
        input  fire, team_id, freq_sel, ammo_load, ammo_val,
        output ir_freq, busy, shot_done, fire_drop, ammo
    );
endinterface

// File: rtl/ir_shot_sequencer_unit_timer.sv
// Loadable down-counter shared by every frame segment and the cooldown.
// Loading N makes expire pulse in the Nth cycle after the load edge.
module ir_unit_timer #(
    parameter int W = 26
) (
    input  logic         PCLK,
    input  logic         PRESET,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expire
);

    logic [W-1:0] count_reg;
    logic         run_reg;

    assign expire = run_reg && (count_reg == '0);

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            count_reg <= '0;
            run_reg   <= 1'b0;
        end else if (load) begin
            count_reg <= load_val - 1'b1;
            run_reg   <= 1'b1;
        end else if (expire) begin
            run_reg   <= 1'b0;
        end else if (run_reg) begin
            count_reg <= count_reg - 1'b1;
        end
    end

endmodule

// File: rtl/ir_shot_sequencer.sv
// Turns an accepted fire pulse into a team-coded IR frame by gating the
// carrier code, then holds off further shots for a cooldown period.
module ir_shot_sequencer
    import ir_seq_pkg::*;
#(
    parameter int unsigned UNIT_CYC     = 60000,
    parameter int unsigned COOLDOWN_CYC = 50000000
) (
    input  logic                PCLK,
    input  logic                PRESET,
    ir_shot_sequencer_if.slave  bus
);

    localparam int unsigned HDR_CYC = HDR_MARK_UNITS * UNIT_CYC;
    localparam int unsigned MAX_CYC = (COOLDOWN_CYC > HDR_CYC) ? COOLDOWN_CYC : HDR_CYC;
    localparam int          TIMER_W = $clog2(MAX_CYC + 1);

    localparam logic [TIMER_W-1:0] HDR_LOAD   = TIMER_W'(HDR_CYC);
    localparam logic [TIMER_W-1:0] SPACE_LOAD = TIMER_W'(SPACE_UNITS * UNIT_CYC);
    localparam logic [TIMER_W-1:0] ONE_LOAD   = TIMER_W'(ONE_MARK_UNITS * UNIT_CYC);
    localparam logic [TIMER_W-1:0] ZERO_LOAD  = TIMER_W'(ZERO_MARK_UNITS * UNIT_CYC);
    localparam logic [TIMER_W-1:0] COOL_LOAD  = TIMER_W'(COOLDOWN_CYC);

    seq_state_t         state_reg, state_next;
    logic [1:0]         bit_idx_reg, bit_idx_next;
    logic [3:0]         team_reg;
    logic [5:0]         freq_reg;
    logic [7:0]         ammo_reg, ammo_next;
    logic [5:0]         ir_freq_reg, ir_freq_next;
    logic               busy_reg, busy_next;
    logic               shot_done_reg, shot_done_next;
    logic               fire_drop_reg, fire_drop_next;
    logic               accept;
    logic               timer_load;
    logic [TIMER_W-1:0] timer_val;
    logic               timer_expire;

    ir_unit_timer #(.W(TIMER_W)) u_timer (
        .PCLK     (PCLK),
        .PRESET   (PRESET),
        .load     (timer_load),
        .load_val (timer_val),
        .expire   (timer_expire)
    );

    assign accept = bus.fire && (state_reg == IDLE) && (ammo_reg != 8'd0)
                    && freq_legal(bus.freq_sel);

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_reg     <= IDLE;
            bit_idx_reg   <= 2'd0;
            team_reg      <= 4'd0;
            freq_reg      <= FREQ_OFF;
            ammo_reg      <= 8'd0;
            ir_freq_reg   <= FREQ_OFF;
            busy_reg      <= 1'b0;
            shot_done_reg <= 1'b0;
            fire_drop_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            bit_idx_reg   <= bit_idx_next;
            ammo_reg      <= ammo_next;
            ir_freq_reg   <= ir_freq_next;
            busy_reg      <= busy_next;
            shot_done_reg <= shot_done_next;
            fire_drop_reg <= fire_drop_next;
            if (accept) begin
                team_reg <= bus.team_id;
                freq_reg <= bus.freq_sel;
            end
        end
    end

    // Every segment change reloads the timer on the same edge, so segments abut.
    always_comb begin
        state_next   = state_reg;
        bit_idx_next = bit_idx_reg;
        timer_load   = 1'b0;
        timer_val    = SPACE_LOAD;
        case (state_reg)
            IDLE: if (accept) begin
                state_next   = HDR_MARK;
                bit_idx_next = 2'd3;
                timer_load   = 1'b1;
                timer_val    = HDR_LOAD;
            end
            HDR_MARK: if (timer_expire) begin
                state_next = HDR_SPACE;
                timer_load = 1'b1;
            end
            HDR_SPACE: if (timer_expire) begin
                state_next = BIT_MARK;
                timer_load = 1'b1;
                timer_val  = team_reg[bit_idx_reg] ? ONE_LOAD : ZERO_LOAD;
            end
            BIT_MARK: if (timer_expire) begin
                state_next = BIT_SPACE;
                timer_load = 1'b1;
            end
            BIT_SPACE: if (timer_expire) begin
                timer_load = 1'b1;
                if (bit_idx_reg != 2'd0) begin
                    state_next   = BIT_MARK;
                    bit_idx_next = bit_idx_reg - 2'd1;
                    timer_val    = team_reg[bit_idx_next] ? ONE_LOAD : ZERO_LOAD;
                end else begin
                    state_next = COOLDOWN;
                    timer_val  = COOL_LOAD;
                end
            end
            COOLDOWN: if (timer_expire) begin
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs are computed from the next state and registered alongside it.
    always_comb begin
        ir_freq_next = FREQ_OFF;
        if (is_mark(state_next)) begin
            ir_freq_next = accept ? bus.freq_sel : freq_reg;
        end
        busy_next      = (state_next != IDLE);
        shot_done_next = (state_reg == BIT_SPACE) && (state_next == COOLDOWN);
        fire_drop_next = bus.fire && !accept;
        ammo_next      = ammo_reg;
        if (bus.ammo_load) begin
            ammo_next = bus.ammo_val;
        end else if (accept) begin
            ammo_next = ammo_reg - 8'd1;
        end
    end

    assign bus.ir_freq   = ir_freq_reg;
    assign bus.busy      = busy_reg;
    assign bus.shot_done = shot_done_reg;
    assign bus.fire_drop = fire_drop_reg;
    assign bus.ammo      = ammo_reg;

endmodule

// File: tb/tb_ir_shot_sequencer.sv
// Bench for ir_shot_sequencer: directed scenarios plus random fire traffic,
// checked every cycle against a waveform-level reference model.
module tb_ir_shot_sequencer;

    localparam int U  = 4;
    localparam int CD = 10;

    logic PCLK   = 1'b0;
    logic PRESET = 1'b1;

    always #5 PCLK = ~PCLK;

    ir_shot_sequencer_if bus();

    ir_shot_sequencer #(.UNIT_CYC(U), .COOLDOWN_CYC(CD)) dut (
        .PCLK   (PCLK),
        .PRESET (PRESET),
        .bus    (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Model: one entry per future busy cycle, freq in [7:0], shot_done in bit 8.
    int   wave[$];
    int   m_ammo   = 0;
    logic exp_drop = 1'b0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic void push_n(int n, int v);
        for (int i = 0; i < n; i++) wave.push_back(v);
    endfunction

    function automatic void build_frame(logic [3:0] team, int f);
        push_n(4 * U, f);
        push_n(U, 0);
        for (int b = 3; b >= 0; b--) begin
            push_n((team[b] ? 2 : 1) * U, f);
            push_n(U, 0);
        end
        wave.push_back(256);
        push_n(CD - 1, 0);
    endfunction

    task automatic step();
        logic idle;
        logic acc;
        @(posedge PCLK);
        if (PRESET) begin
            wave.delete();
            m_ammo   = 0;
            exp_drop = 1'b0;
        end else begin
            idle = (wave.size() == 0);
            if (!idle) void'(wave.pop_front());
            acc = bus.fire && idle && (m_ammo != 0) &&
                  (bus.freq_sel == 6'd56 || bus.freq_sel == 6'd38);
            exp_drop = bus.fire && !acc;
            if (acc) begin
                build_frame(bus.team_id, int'(bus.freq_sel));
                $display("cycle %0d: fire accepted team=%b freq=%0d ammo=%0d",
                         cyc, bus.team_id, bus.freq_sel, m_ammo);
            end else if (bus.fire) begin
                $display("cycle %0d: fire dropped freq=%0d ammo=%0d busy=%0d",
                         cyc, bus.freq_sel, m_ammo, !idle);
            end
            if (bus.ammo_load) m_ammo = int'(bus.ammo_val);
            else if (acc) m_ammo = m_ammo - 1;
        end
        cyc++;
        @(negedge PCLK);
        chk("ir_freq",   int'(bus.ir_freq),   (wave.size() != 0) ? (wave[0] & 255) : 0);
        chk("busy",      int'(bus.busy),      (wave.size() != 0) ? 1 : 0);
        chk("shot_done", int'(bus.shot_done), (wave.size() != 0) ? (wave[0] >> 8) : 0);
        chk("fire_drop", int'(bus.fire_drop), int'(exp_drop));
        chk("ammo",      int'(bus.ammo),      m_ammo);
        bus.fire      = 1'b0;
        bus.ammo_load = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (wave.size() != 0 && n < 200) begin
            step();
            n++;
        end
        if (wave.size() != 0) chk("idle_timeout", n, 0);
    endtask

    task automatic fire_req(input logic [3:0] team, input logic [5:0] f);
        bus.fire     = 1'b1;
        bus.team_id  = team;
        bus.freq_sel = f;
    endtask

    task automatic load_ammo(input logic [7:0] v);
        bus.ammo_load = 1'b1;
        bus.ammo_val  = v;
    endtask

    initial begin
        int lat;
        int r;
        bus.fire      = 1'b0;
        bus.team_id   = 4'd0;
        bus.freq_sel  = 6'd0;
        bus.ammo_load = 1'b0;
        bus.ammo_val  = 8'd0;

        step();
        step();
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_ammo", int'(bus.ammo), 0);
        PRESET = 1'b0;
        step();

        // Frame shape and shot_done latency for team 1010 at 56
        load_ammo(8'd3);
        step();
        fire_req(4'b1010, 6'd56);
        step();
        lat = 1;
        while (bus.shot_done !== 1'b1 && lat < 200) begin
            step();
            lat++;
        end
        chk("shot_lat", lat, 61);
        wait_idle();
        chk("ammo_after_1", int'(bus.ammo), 2);

        // Fires during a frame are dropped
        fire_req(4'b0110, 6'd38);
        step();
        repeat (10) step();
        fire_req(4'b1111, 6'd56);
        step();
        repeat (15) step();
        fire_req(4'b0000, 6'd38);
        step();
        wait_idle();
        chk("ammo_after_2", int'(bus.ammo), 1);

        // Empty magazine and illegal carrier
        load_ammo(8'd0);
        step();
        fire_req(4'b0101, 6'd56);
        step();
        chk("empty_busy", int'(bus.busy), 0);
        chk("empty_drop", int'(bus.fire_drop), 1);
        load_ammo(8'd2);
        step();
        fire_req(4'b0101, 6'd40);
        step();
        chk("badfreq_drop", int'(bus.fire_drop), 1);
        chk("badfreq_busy", int'(bus.busy), 0);

        // Load coinciding with accept wins
        fire_req(4'b0011, 6'd38);
        load_ammo(8'd5);
        step();
        chk("load_win_busy", int'(bus.busy), 1);
        wait_idle();
        chk("load_win_ammo", int'(bus.ammo), 5);

        // Asynchronous reset during a bit mark
        fire_req(4'b1001, 6'd56);
        step();
        repeat (21) step();
        chk("pre_rst_freq", int'(bus.ir_freq), 56);
        #2 PRESET = 1'b1;
        #1;
        chk("async_freq", int'(bus.ir_freq), 0);
        chk("async_busy", int'(bus.busy), 0);
        chk("async_ammo", int'(bus.ammo), 0);
        step();
        step();
        PRESET = 1'b0;
        step();
        load_ammo(8'd2);
        step();
        fire_req(4'b1100, 6'd38);
        step();
        wait_idle();

        // Fire in the cycle busy falls is accepted
        fire_req(4'b0111, 6'd56);
        step();
        chk("refire_busy", int'(bus.busy), 1);
        chk("refire_freq", int'(bus.ir_freq), 56);
        wait_idle();

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 11) == 0) begin
                r = $urandom_range(0, 3);
                fire_req(4'($urandom_range(0, 15)),
                         (r < 2) ? 6'd56 : (r == 2) ? 6'd38 : 6'($urandom_range(0, 63)));
            end
            if ($urandom_range(0, 39) == 0) load_ammo(8'($urandom_range(0, 4)));
            step();
        end
        wait_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
